// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - demand-actuated N-phase signal sequencer with emergency preempt
module traffic_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_T    = 7,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_PHASES-1:0]   demand,
    input  logic                    preempt,
    output logic [3*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         phase,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_RELOAD  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_RELOAD = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_RELOAD = CNT_W'(ALLRED_T - 1);

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [PH_W-1:0]  next_ph_q, next_ph_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  scan_ph;
    logic             scan_found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_GREEN;
            phase_q   <= '0;
            next_ph_q <= '0;
            cnt_q     <= GREEN_RELOAD;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            next_ph_q <= next_ph_d;
            cnt_q     <= cnt_d;
        end
    end

    // Cyclic scan from phase+1; phase 0 is always eligible so the scan only
    // falls through (keeping the current phase) when resting on phase 0.
    always_comb begin
        int cand;
        scan_ph    = phase_q;
        scan_found = 1'b0;
        cand       = 0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            cand = (int'(phase_q) + k) % NUM_PHASES;
            if (!scan_found && (cand == 0 || demand[cand])) begin
                scan_found = 1'b1;
                scan_ph    = PH_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        next_ph_d = next_ph_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_GREEN: begin
                if (preempt) begin
                    state_d   = ST_YELLOW;
                    cnt_d     = YELLOW_RELOAD;
                    next_ph_d = '0;
                end else if (tick) begin
                    if (cnt_q == '0) begin
                        next_ph_d = scan_ph;
                        if (scan_ph == phase_q) begin
                            cnt_d = GREEN_RELOAD;
                        end else begin
                            state_d = ST_YELLOW;
                            cnt_d   = YELLOW_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = ST_ALLRED;
                        cnt_d   = ALLRED_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_ALLRED: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        if (preempt) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_GREEN;
                            phase_d = next_ph_q;
                            cnt_d   = GREEN_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                if (!preempt) begin
                    state_d   = ST_ALLRED;
                    cnt_d     = ALLRED_RELOAD;
                    next_ph_d = '0;
                end
            end
        endcase
    end

    // Only the served phase can ever leave red, which gives the one-non-red invariant by construction.
    always_comb begin
        lights = {NUM_PHASES{3'b100}};
        case (state_q)
            ST_GREEN:  lights[3*int'(phase_q) +: 3] = 3'b001;
            ST_YELLOW: lights[3*int'(phase_q) +: 3] = 3'b010;
            default:   lights = {NUM_PHASES{3'b100}};
        endcase
    end

    assign phase   = phase_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - table-driven scoreboard bench for traffic_phase_sequencer
module tb_traffic_phase_sequencer;

    localparam bit [1:0] SG = 2'b00;
    localparam bit [1:0] SY = 2'b01;
    localparam bit [1:0] SA = 2'b10;
    localparam bit [1:0] SH = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        preempt = 1'b0;
    logic [3:0]  demand = 4'b0000;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .NUM_PHASES(4),
        .CNT_W(8),
        .GREEN_T(7),
        .YELLOW_T(3),
        .ALLRED_T(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .demand(demand),
        .preempt(preempt),
        .lights(lights),
        .phase(phase),
        .state_o(state_o)
    );

    typedef struct {
        string    name;
        bit       async_rst;
        bit       tick;
        bit [3:0] demand;
        bit       preempt;
        int       n;
        bit [11:0] lights;
        bit [1:0] phase;
        bit [1:0] state;
    } vec_t;

    typedef struct {
        bit [11:0] lights;
        bit [1:0]  phase;
        bit [1:0]  state;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input string nm, input bit ar, input bit t, input bit [3:0] d,
                                input bit p, input int n, input bit [11:0] l,
                                input bit [1:0] ph, input bit [1:0] s);
        vec_t v;
        v.name = nm; v.async_rst = ar; v.tick = t; v.demand = d; v.preempt = p;
        v.n = n; v.lights = l; v.phase = ph; v.state = s;
        return v;
    endfunction

    task automatic push_exp(input bit [11:0] l, input bit [1:0] ph, input bit [1:0] s);
        exp_t e;
        e.lights = l; e.phase = ph; e.state = s;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
        end else begin
            e = exp_q.pop_front();
            if (lights !== e.lights || phase !== e.phase || state_o !== e.state) begin
                failures++;
                $display("FAIL %s: got lights=%03h phase=%0d state=%0d, want lights=%03h phase=%0d state=%0d (t=%0t)",
                         name, lights, phase, state_o, e.lights, e.phase, e.state, $time);
            end
        end
    endtask

    task automatic step(input bit t, input bit [3:0] d, input bit p, input bit [11:0] l,
                        input bit [1:0] ph, input bit [1:0] s, input string name);
        tick = t; demand = d; preempt = p;
        push_exp(l, ph, s);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    // Called 1 time unit after an edge (or at time 0): reset lands mid-cycle, away from any edge.
    task automatic async_reset(input string name);
        #3;
        rst = 1'b1; tick = 1'b0; demand = 4'b0000; preempt = 1'b0;
        #1;
        push_exp(12'h921, 2'd0, SG);
        check_out(name);
        @(posedge clk);
        #1;
        push_exp(12'h921, 2'd0, SG);
        check_out({name, "_held"});
        rst = 1'b0;
    endtask

    initial begin
        vecs.push_back(mk("reset_init",   1, 0, 4'b0000, 0,  0, 12'h921, 0, SG));
        vecs.push_back(mk("rest_green",   0, 1, 4'b0000, 0, 30, 12'h921, 0, SG));
        vecs.push_back(mk("reset2",       1, 0, 4'b0000, 0,  0, 12'h921, 0, SG));
        vecs.push_back(mk("d4_g0",        0, 1, 4'b0100, 0,  6, 12'h921, 0, SG));
        vecs.push_back(mk("d4_y0",        0, 1, 4'b0100, 0,  3, 12'h922, 0, SY));
        vecs.push_back(mk("d4_r0",        0, 1, 4'b0100, 0,  1, 12'h924, 0, SA));
        vecs.push_back(mk("d4_g2",        0, 1, 4'b0100, 0,  7, 12'h864, 2, SG));
        vecs.push_back(mk("d4_y2",        0, 1, 4'b0100, 0,  2, 12'h8A4, 2, SY));
        vecs.push_back(mk("reset_mid_y2", 1, 0, 4'b0000, 0,  0, 12'h921, 0, SG));
        vecs.push_back(mk("da_g0",        0, 1, 4'b1010, 0,  6, 12'h921, 0, SG));
        vecs.push_back(mk("da_y0",        0, 1, 4'b1010, 0,  3, 12'h922, 0, SY));
        vecs.push_back(mk("da_r0",        0, 1, 4'b1010, 0,  1, 12'h924, 0, SA));
        vecs.push_back(mk("da_g1",        0, 1, 4'b1010, 0,  7, 12'h90C, 1, SG));
        vecs.push_back(mk("da_y1",        0, 1, 4'b1010, 0,  3, 12'h914, 1, SY));
        vecs.push_back(mk("da_r1",        0, 1, 4'b1010, 0,  1, 12'h924, 1, SA));
        vecs.push_back(mk("da_g3",        0, 1, 4'b1010, 0,  7, 12'h324, 3, SG));
        vecs.push_back(mk("da_y3",        0, 1, 4'b1010, 0,  3, 12'h524, 3, SY));
        vecs.push_back(mk("da_r3",        0, 1, 4'b1010, 0,  1, 12'h924, 3, SA));
        vecs.push_back(mk("da_g0b",       0, 1, 4'b1010, 0,  7, 12'h921, 0, SG));
        vecs.push_back(mk("da_y0b",       0, 1, 4'b1010, 0,  3, 12'h922, 0, SY));
        vecs.push_back(mk("da_r0b",       0, 1, 4'b1010, 0,  1, 12'h924, 0, SA));
        vecs.push_back(mk("da_g1b",       0, 1, 4'b1010, 0,  7, 12'h90C, 1, SG));
        vecs.push_back(mk("reset3",       1, 0, 4'b0000, 0,  0, 12'h921, 0, SG));
        vecs.push_back(mk("pe_g0",        0, 1, 4'b0100, 0,  6, 12'h921, 0, SG));
        vecs.push_back(mk("pe_y0",        0, 1, 4'b0100, 0,  3, 12'h922, 0, SY));
        vecs.push_back(mk("pe_r0",        0, 1, 4'b0100, 0,  1, 12'h924, 0, SA));
        vecs.push_back(mk("pe_g2",        0, 1, 4'b0100, 0,  3, 12'h864, 2, SG));
        vecs.push_back(mk("pe_y2",        0, 1, 4'b0100, 1,  3, 12'h8A4, 2, SY));
        vecs.push_back(mk("pe_r2",        0, 1, 4'b0100, 1,  1, 12'h924, 2, SA));
        vecs.push_back(mk("pe_hold",      0, 1, 4'b0100, 1,  6, 12'h924, 2, SH));
        vecs.push_back(mk("pe_release",   0, 1, 4'b0100, 0,  1, 12'h924, 2, SA));
        vecs.push_back(mk("pe_resume",    0, 1, 4'b0100, 0,  1, 12'h921, 0, SG));
        vecs.push_back(mk("reset4",       1, 0, 4'b0000, 0,  0, 12'h921, 0, SG));

        foreach (vecs[i]) begin
            if (vecs[i].async_rst) begin
                async_reset(vecs[i].name);
            end else begin
                for (int k = 0; k < vecs[i].n; k++) begin
                    step(vecs[i].tick, vecs[i].demand, vecs[i].preempt,
                         vecs[i].lights, vecs[i].phase, vecs[i].state, vecs[i].name);
                end
            end
        end

        // Tick on every 4th clk: 7 ticks of green span 28 clk including the reset cycle.
        for (int c = 0; c < 40; c++) begin
            if (c < 27)
                step((c % 4) == 3, 4'b0010, 1'b0, 12'h921, 2'd0, SG, "slow_green");
            else if (c < 39)
                step((c % 4) == 3, 4'b0010, 1'b0, 12'h922, 2'd0, SY, "slow_yellow");
            else
                step((c % 4) == 3, 4'b0010, 1'b0, 12'h924, 2'd0, SA, "slow_allred");
        end

        for (int c = 0; c < 50; c++) begin
            step(1'b0, 4'b0010, 1'b0, 12'h924, 2'd0, SA, "tick_frozen");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
